picorv32_freeahb_bridge: RTL and testbench

Second-generation bridge between the PicoRV32 native memory interface and the FreeAHB master user interface. It sits between the core and the FreeAHB master in the GRLIB-integrated RISC-V subsystem. It replaces byte-per-strobe writes with naturally aligned word, halfword and byte transfers on correct AHB byte lanes for either endianness, and registers read data. It adds a per-transfer watchdog that terminates hung transactions with an error indication.

---
 rtl/picorv32_freeahb_bridge.sv | 221 ++++++++++++++++++++++
 tb/tb_picorv32_freeahb_bridge.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_freeahb_bridge.sv
// PicoRV32 native memory port to FreeAHB master UI bridge: lane-correct sized
// write chunking, registered read data, and a per-transfer watchdog.
module picorv32_freeahb_bridge #(
    parameter bit          BIG_ENDIAN_AHB = 1'b1,
    parameter bit          MERGE_STROBES  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        freeahb_valid,
    output logic        freeahb_read,
    output logic        freeahb_write,
    output logic        freeahb_cont,
    output logic        freeahb_lock,
    output logic [31:0] freeahb_addr,
    output logic [31:0] freeahb_wdata,
    output logic [31:0] freeahb_min_len,
    output logic [2:0]  freeahb_size,
    output logic [3:0]  freeahb_prot,
    input  logic        freeahb_next,
    input  logic        freeahb_ready,
    input  logic [31:0] freeahb_rdata,
    input  logic [31:0] freeahb_result_addr,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t      state;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  pend;
    logic        req_read;
    logic [15:0] wd_cnt;

    logic [3:0]  src_strb;
    logic [31:0] src_data;
    logic [31:0] src_addr;
    logic [3:0]  c_mask;
    logic [1:0]  c_off;
    logic [2:0]  c_size;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [31:0] rd_lanes;
    logic        wd_hit;
    logic        unused_result_addr;

    assign freeahb_cont       = 1'b0;
    assign freeahb_lock       = 1'b0;
    assign freeahb_min_len    = '0;
    assign unused_result_addr = ^freeahb_result_addr;

    // Lanes covered by the next transfer, taken from the lowest pending strobe.
    function automatic logic [3:0] chunk_mask(input logic [3:0] s);
        logic [3:0] m;
        m = '0;
        if (MERGE_STROBES && s == 4'b1111) m = 4'b1111;
        else if (s[0]) m = (MERGE_STROBES && s[1]) ? 4'b0011 : 4'b0001;
        else if (s[1]) m = 4'b0010;
        else if (s[2]) m = (MERGE_STROBES && s[3]) ? 4'b1100 : 4'b0100;
        else if (s[3]) m = 4'b1000;
        return m;
    endfunction

    function automatic logic [31:0] place(input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            if (m[j]) begin
                if (BIG_ENDIAN_AHB) r[8*(3-j) +: 8] = d[8*j +: 8];
                else                r[8*j +: 8]     = d[8*j +: 8];
            end
        end
        return r;
    endfunction

    always_comb begin
        src_strb = (state == IDLE) ? mem_wstrb : pend;
        src_data = (state == IDLE) ? mem_wdata : req_wdata;
        src_addr = (state == IDLE) ? mem_addr  : req_addr;
        c_mask   = chunk_mask(src_strb);
        c_off    = 2'd3;
        if (c_mask[0])      c_off = 2'd0;
        else if (c_mask[1]) c_off = 2'd1;
        else if (c_mask[2]) c_off = 2'd2;
        c_size   = 3'b000;
        if (c_mask == 4'b1111)                          c_size = 3'b010;
        else if (c_mask == 4'b0011 || c_mask == 4'b1100) c_size = 3'b001;
        c_addr   = src_addr + {30'd0, c_off};
        c_wdata  = place(src_data, c_mask);
        rd_lanes = BIG_ENDIAN_AHB ? {freeahb_rdata[7:0], freeahb_rdata[15:8],
                                     freeahb_rdata[23:16], freeahb_rdata[31:24]}
                                  : freeahb_rdata;
        wd_hit   = (TIMEOUT_CYCLES != 0) && (({16'd0, wd_cnt} + 32'd1) >= TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            req_addr      <= '0;
            req_wdata     <= '0;
            pend          <= '0;
            req_read      <= 1'b0;
            wd_cnt        <= '0;
            mem_ready     <= 1'b0;
            mem_rdata     <= '0;
            bus_error     <= 1'b0;
            freeahb_valid <= 1'b0;
            freeahb_read  <= 1'b0;
            freeahb_write <= 1'b0;
            freeahb_addr  <= '0;
            freeahb_wdata <= '0;
            freeahb_size  <= '0;
            freeahb_prot  <= '0;
        end else begin
            mem_ready <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        req_addr      <= mem_addr;
                        req_wdata     <= mem_wdata;
                        wd_cnt        <= '0;
                        freeahb_valid <= 1'b1;
                        freeahb_prot  <= mem_instr ? 4'b0000 : 4'b0001;
                        state         <= ISSUE;
                        if (mem_wstrb == 4'b0000) begin
                            req_read      <= 1'b1;
                            freeahb_read  <= 1'b1;
                            freeahb_write <= 1'b0;
                            freeahb_addr  <= mem_addr;
                            freeahb_size  <= 3'b010;
                            freeahb_wdata <= '0;
                            pend          <= '0;
                        end else begin
                            req_read      <= 1'b0;
                            freeahb_read  <= 1'b0;
                            freeahb_write <= 1'b1;
                            freeahb_addr  <= c_addr;
                            freeahb_size  <= c_size;
                            freeahb_wdata <= c_wdata;
                            pend          <= mem_wstrb & ~c_mask;
                        end
                    end
                end
                ISSUE: begin
                    if (freeahb_next) begin
                        if (req_read) begin
                            freeahb_valid <= 1'b0;
                            freeahb_read  <= 1'b0;
                            if (freeahb_ready) begin
                                if (mem_valid) begin
                                    mem_rdata <= rd_lanes;
                                    mem_ready <= 1'b1;
                                    state     <= RESP;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                wd_cnt <= wd_cnt + 16'd1;
                                state  <= RDWAIT;
                            end
                        end else if (pend != 4'b0000 && mem_valid) begin
                            freeahb_addr  <= c_addr;
                            freeahb_size  <= c_size;
                            freeahb_wdata <= c_wdata;
                            pend          <= pend & ~c_mask;
                            wd_cnt        <= '0;
                        end else begin
                            freeahb_valid <= 1'b0;
                            freeahb_write <= 1'b0;
                            pend          <= '0;
                            mem_ready     <= mem_valid;
                            state         <= mem_valid ? RESP : IDLE;
                        end
                    end else if (wd_hit) begin
                        freeahb_valid <= 1'b0;
                        freeahb_read  <= 1'b0;
                        freeahb_write <= 1'b0;
                        pend          <= '0;
                        if (req_read && mem_valid) mem_rdata <= ERR_RDATA;
                        mem_ready     <= mem_valid;
                        bus_error     <= mem_valid;
                        state         <= mem_valid ? RESP : IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                RDWAIT: begin
                    if (freeahb_ready) begin
                        if (mem_valid) begin
                            mem_rdata <= rd_lanes;
                            mem_ready <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wd_hit) begin
                        if (mem_valid) mem_rdata <= ERR_RDATA;
                        mem_ready <= mem_valid;
                        bus_error <= mem_valid;
                        state     <= mem_valid ? RESP : IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_freeahb_bridge.sv
// Directed bench: a BE/merging/watchdog bridge and an LE/byte-only bridge share stimulus.
module tb_picorv32_freeahb_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        next = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] result_addr = '0;

    logic        be_mem_ready, be_valid, be_read, be_write, be_cont, be_lock, be_bus_error;
    logic [31:0] be_mem_rdata, be_addr, be_wdata, be_min_len;
    logic [2:0]  be_size;
    logic [3:0]  be_prot;
    logic        le_mem_ready, le_valid, le_read, le_write, le_cont, le_lock, le_bus_error;
    logic [31:0] le_mem_rdata, le_addr, le_wdata, le_min_len;
    logic [2:0]  le_size;
    logic [3:0]  le_prot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    picorv32_freeahb_bridge #(
        .BIG_ENDIAN_AHB(1'b1), .MERGE_STROBES(1'b1), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)
    ) u_be (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(be_mem_ready), .mem_rdata(be_mem_rdata),
        .freeahb_valid(be_valid), .freeahb_read(be_read), .freeahb_write(be_write),
        .freeahb_cont(be_cont), .freeahb_lock(be_lock), .freeahb_addr(be_addr),
        .freeahb_wdata(be_wdata), .freeahb_min_len(be_min_len), .freeahb_size(be_size),
        .freeahb_prot(be_prot), .freeahb_next(next), .freeahb_ready(ready),
        .freeahb_rdata(rdata), .freeahb_result_addr(result_addr), .bus_error(be_bus_error)
    );

    picorv32_freeahb_bridge #(
        .BIG_ENDIAN_AHB(1'b0), .MERGE_STROBES(1'b0), .TIMEOUT_CYCLES(0), .ERR_RDATA(32'hDEAD_BEEF)
    ) u_le (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(le_mem_ready), .mem_rdata(le_mem_rdata),
        .freeahb_valid(le_valid), .freeahb_read(le_read), .freeahb_write(le_write),
        .freeahb_cont(le_cont), .freeahb_lock(le_lock), .freeahb_addr(le_addr),
        .freeahb_wdata(le_wdata), .freeahb_min_len(le_min_len), .freeahb_size(le_size),
        .freeahb_prot(le_prot), .freeahb_next(next), .freeahb_ready(ready),
        .freeahb_rdata(rdata), .freeahb_result_addr(result_addr), .bus_error(le_bus_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        mem_valid = 1'b0;
        mem_wstrb = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if ({be_mem_ready, be_valid, be_read, be_write, be_bus_error} !== 5'b0) begin errors++; $display("FAIL reset_be_ctrl got=%b exp=00000", {be_mem_ready, be_valid, be_read, be_write, be_bus_error}); end
        checks++; if ({be_mem_rdata, be_addr, be_wdata} !== 96'h0) begin errors++; $display("FAIL reset_be_data got=%h exp=0", {be_mem_rdata, be_addr, be_wdata}); end
        checks++; if ({be_size, be_prot, be_cont, be_lock, be_min_len} !== 41'h0) begin errors++; $display("FAIL reset_be_misc got=%h exp=0", {be_size, be_prot, be_cont, be_lock, be_min_len}); end
        checks++; if ({le_mem_ready, le_valid, le_mem_rdata, le_size, le_prot} !== 41'h0) begin errors++; $display("FAIL reset_le got=%h exp=0", {le_mem_ready, le_valid, le_mem_rdata, le_size, le_prot}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_read(input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_be, input logic [31:0] exp_le);
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = a; mem_wstrb = 4'b0000;
        rdata = d; next = 1'b1; ready = 1'b0;
        step();
        checks++; if ({be_valid, be_read, be_write} !== 3'b110) begin errors++; $display("FAIL rd_ctrl got=%b exp=110", {be_valid, be_read, be_write}); end
        checks++; if (be_addr !== a) begin errors++; $display("FAIL rd_addr got=%h exp=%h", be_addr, a); end
        checks++; if ({be_size, be_prot} !== 7'b010_0001) begin errors++; $display("FAIL rd_size_prot got=%b exp=0100001", {be_size, be_prot}); end
        step();
        ready = 1'b1;
        checks++; if ({be_valid, be_mem_ready} !== 2'b00) begin errors++; $display("FAIL rd_wait got=%b exp=00", {be_valid, be_mem_ready}); end
        step();
        ready = 1'b0;
        checks++; if ({be_mem_ready, be_bus_error, le_mem_ready} !== 3'b101) begin errors++; $display("FAIL rd_ready got=%b exp=101", {be_mem_ready, be_bus_error, le_mem_ready}); end
        checks++; if (be_mem_rdata !== exp_be) begin errors++; $display("FAIL rd_data_be got=%h exp=%h", be_mem_rdata, exp_be); end
        checks++; if (le_mem_rdata !== exp_le) begin errors++; $display("FAIL rd_data_le got=%h exp=%h", le_mem_rdata, exp_le); end
        mem_valid = 1'b0;
        step();
        checks++; if ({be_mem_ready, be_mem_rdata} !== {1'b0, exp_be}) begin errors++; $display("FAIL rd_hold got=%h exp=%h", {be_mem_ready, be_mem_rdata}, {1'b0, exp_be}); end
        idle_cycles(2);
    endtask

    task automatic test_word_write();
        mem_valid = 1'b1; mem_addr = 32'h4000_0008; mem_wstrb = 4'b1111;
        mem_wdata = 32'hAABB_CCDD; next = 1'b1; ready = 1'b0;
        step();
        checks++; if ({be_valid, be_write, be_read, be_size} !== 6'b110_010) begin errors++; $display("FAIL ww_ctrl got=%b exp=110010", {be_valid, be_write, be_read, be_size}); end
        checks++; if ({be_addr, be_wdata} !== {32'h4000_0008, 32'hDDCC_BBAA}) begin errors++; $display("FAIL ww_be got=%h exp=40000008ddccbbaa", {be_addr, be_wdata}); end
        checks++; if ({le_addr, le_wdata, le_size} !== {32'h4000_0008, 32'h0000_00DD, 3'b000}) begin errors++; $display("FAIL ww_le0 got=%h", {le_addr, le_wdata, le_size}); end
        step();
        checks++; if ({be_mem_ready, be_valid} !== 2'b10) begin errors++; $display("FAIL ww_ready got=%b exp=10", {be_mem_ready, be_valid}); end
        checks++; if ({le_addr, le_wdata, le_mem_ready} !== {32'h4000_0009, 32'h0000_CC00, 1'b0}) begin errors++; $display("FAIL ww_le1 got=%h", {le_addr, le_wdata, le_mem_ready}); end
        mem_valid = 1'b0;
        step();
        checks++; if ({le_valid, le_mem_ready, be_mem_ready} !== 3'b000) begin errors++; $display("FAIL ww_drop got=%b exp=000", {le_valid, le_mem_ready, be_mem_ready}); end
        idle_cycles(2);
    endtask

    task automatic test_split_be();
        mem_valid = 1'b1; mem_addr = 32'h4000_0010; mem_wstrb = 4'b0111;
        mem_wdata = 32'h0033_2211; next = 1'b1;
        step();
        checks++; if ({be_addr, be_wdata, be_size} !== {32'h4000_0010, 32'h1122_0000, 3'b001}) begin errors++; $display("FAIL sb_half got=%h", {be_addr, be_wdata, be_size}); end
        checks++; if ({le_addr, le_wdata, le_size} !== {32'h4000_0010, 32'h0000_0011, 3'b000}) begin errors++; $display("FAIL sb_le0 got=%h", {le_addr, le_wdata, le_size}); end
        step();
        checks++; if ({be_valid, be_mem_ready, be_addr, be_wdata, be_size} !== {2'b10, 32'h4000_0012, 32'h0000_3300, 3'b000}) begin errors++; $display("FAIL sb_byte got=%h", {be_valid, be_mem_ready, be_addr, be_wdata, be_size}); end
        step();
        checks++; if ({be_mem_ready, be_valid, le_mem_ready} !== 3'b100) begin errors++; $display("FAIL sb_ready got=%b exp=100", {be_mem_ready, be_valid, le_mem_ready}); end
        idle_cycles(3);
    endtask

    task automatic test_split_le();
        mem_valid = 1'b1; mem_addr = 32'h2000_0100; mem_wstrb = 4'b1010;
        mem_wdata = 32'h4433_2211; next = 1'b1;
        step();
        checks++; if ({le_addr, le_wdata, le_size} !== {32'h2000_0101, 32'h0000_2200, 3'b000}) begin errors++; $display("FAIL sl_first got=%h", {le_addr, le_wdata, le_size}); end
        checks++; if ({be_addr, be_wdata} !== {32'h2000_0101, 32'h0022_0000}) begin errors++; $display("FAIL sl_be_first got=%h", {be_addr, be_wdata}); end
        step();
        checks++; if ({le_valid, le_addr, le_wdata} !== {1'b1, 32'h2000_0103, 32'h4400_0000}) begin errors++; $display("FAIL sl_second got=%h", {le_valid, le_addr, le_wdata}); end
        checks++; if ({be_addr, be_wdata} !== {32'h2000_0103, 32'h0000_0044}) begin errors++; $display("FAIL sl_be_second got=%h", {be_addr, be_wdata}); end
        step();
        checks++; if ({le_mem_ready, le_bus_error, le_valid, be_mem_ready} !== 4'b1001) begin errors++; $display("FAIL sl_ready got=%b exp=1001", {le_mem_ready, le_bus_error, le_valid, be_mem_ready}); end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_1000; mem_wstrb = 4'b0000;
        rdata = 32'hA1B2_C3D4; next = 1'b1; ready = 1'b1;
        step();
        step();
        checks++; if ({be_mem_ready, be_mem_rdata} !== {1'b1, 32'hD4C3_B2A1}) begin errors++; $display("FAIL bb_first got=%h", {be_mem_ready, be_mem_rdata}); end
        mem_addr = 32'h0000_2000; mem_instr = 1'b1; rdata = 32'h0102_0304;
        step();
        checks++; if ({be_valid, be_mem_ready, le_valid} !== 3'b000) begin errors++; $display("FAIL bb_gap got=%b exp=000", {be_valid, be_mem_ready, le_valid}); end
        step();
        checks++; if ({be_valid, be_addr, be_prot} !== {1'b1, 32'h0000_2000, 4'b0000}) begin errors++; $display("FAIL bb_issue got=%h", {be_valid, be_addr, be_prot}); end
        step();
        checks++; if ({be_mem_ready, be_mem_rdata, le_mem_rdata} !== {1'b1, 32'h0403_0201, 32'h0102_0304}) begin errors++; $display("FAIL bb_second got=%h", {be_mem_ready, be_mem_rdata, le_mem_rdata}); end
        mem_instr = 1'b0; ready = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_timeout();
        int  valid_cycles;
        bit  done;
        valid_cycles = 0;
        done = 1'b0;
        mem_valid = 1'b1; mem_addr = 32'h4000_0020; mem_wstrb = 4'b0000;
        next = 1'b0; ready = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (be_mem_ready) done = 1'b1;
            else if (be_valid) valid_cycles++;
        end
        checks++; if (!done) begin errors++; $display("FAIL to_no_ready got=0 exp=1 within 20 cycles"); end
        checks++; if (valid_cycles !== 8) begin errors++; $display("FAIL to_valid_cycles got=%0d exp=8", valid_cycles); end
        checks++; if ({be_bus_error, be_valid, be_read} !== 3'b100) begin errors++; $display("FAIL to_flags got=%b exp=100", {be_bus_error, be_valid, be_read}); end
        checks++; if (be_mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata got=%h exp=deadbeef", be_mem_rdata); end
        mem_valid = 1'b0;
        step();
        checks++; if ({be_bus_error, be_mem_ready} !== 2'b00) begin errors++; $display("FAIL to_pulse got=%b exp=00", {be_bus_error, be_mem_ready}); end
        next = 1'b1; ready = 1'b1;
        step();
        step();
        checks++; if ({le_valid, le_mem_ready, le_bus_error} !== 3'b000) begin errors++; $display("FAIL to_le_flush got=%b exp=000", {le_valid, le_mem_ready, le_bus_error}); end
        ready = 1'b0;
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        mem_valid = 1'b1; mem_addr = 32'h4000_0030; mem_wstrb = 4'b1111;
        mem_wdata = 32'h1234_5678; next = 1'b0;
        step();
        step();
        checks++; if ({be_valid, be_write} !== 2'b11) begin errors++; $display("FAIL rm_issue got=%b exp=11", {be_valid, be_write}); end
        reset = 1'b1; mem_valid = 1'b0;
        step();
        checks++; if ({be_valid, be_write, be_mem_ready, be_addr, be_wdata, be_size, be_prot, be_mem_rdata} !== 106'h0) begin errors++; $display("FAIL rm_be_zero got=%h", {be_valid, be_write, be_mem_ready, be_addr, be_wdata, be_size, be_prot, be_mem_rdata}); end
        checks++; if ({le_valid, le_write, le_mem_ready, le_addr, le_wdata} !== 67'h0) begin errors++; $display("FAIL rm_le_zero got=%h", {le_valid, le_write, le_mem_ready, le_addr, le_wdata}); end
        reset = 1'b0;
        step();
        checks++; if ({be_mem_ready, le_mem_ready} !== 2'b00) begin errors++; $display("FAIL rm_no_ready got=%b exp=00", {be_mem_ready, le_mem_ready}); end
        test_read(32'h4000_0040, 32'hCAFE_F00D, 32'h0DF0_FECA, 32'hCAFE_F00D);
    endtask

    initial begin
        test_reset();
        test_read(32'h4000_0000, 32'h1122_3344, 32'h4433_2211, 32'h1122_3344);
        test_word_write();
        test_split_be();
        test_split_le();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
